fifo_port_arbiter: RTL and testbench
====================================

Name: fifo_port_arbiter

Overview:
- Shares the single-port FIFO command interface (one op/stb per cycle) between one producer (push) and one consumer (pull).
- Gates each requester on full/empty and resolves same-cycle conflicts round-robin.
- Registers pull data for the consumer.
- Sits between the client logic and the fifo instance and owns the fifo's clk-domain op/stb/data_write inputs.

Parameters:
- DW, 8, data width; must match the fifo DW.
- SIZE, 10, fifo depth in entries; must match the fifo SIZE. Usable capacity is SIZE-1.
- LW, 4, width of the level/occupancy counter; must satisfy 2^LW > SIZE-1.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- push_req  input  1  producer requests a write; held until push_ack.
- push_data  input  DW  write data; stable while push_req is high.
- push_ack  output  1  combinational; high in the cycle the write is issued to the fifo.
- pull_req  input  1  consumer requests a read; held until pull_ack.
- pull_ack  output  1  combinational; high in the cycle the read is issued to the fifo.
- pull_valid  output  1  registered; pulses one cycle after pull_ack.
- pull_data  output  DW  registered; valid while pull_valid is high and held otherwise.
- fifo_op  output  1  to fifo op: 0 = push, 1 = pull.
- fifo_stb  output  1  to fifo stb.
- fifo_data_write  output  DW  to fifo data_write.
- fifo_data_read  input  DW  from fifo data_read; head entry, combinational.
- fifo_full  input  1  from fifo full.
- fifo_empty  input  1  from fifo empty.
- level  output  LW  current entry count (see Optional Feature).

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst). The fifo's pointers have no reset, so rst must only be applied when the fifo is already empty or has been freshly configured.
- Eligibility:
  - push_elig = push_req & ~fifo_full.
  - pull_elig = pull_req & ~fifo_empty.
- Grant, combinational within the cycle:
  - Only one eligible: that side wins.
  - Both eligible: the side not granted last time wins (round-robin).
  - Neither eligible: fifo_stb = 0, no ack.
- On a push grant: fifo_stb = 1, fifo_op = 0, fifo_data_write = push_data, push_ack = 1.
- On a pull grant: fifo_stb = 1, fifo_op = 1, pull_ack = 1. fifo_data_read is captured into pull_data at that clock edge, and pull_valid = 1 in the next cycle only.
- fifo_data_write = push_data at all times; this is don't-care when not pushing.
- last_grant register:
  - 1 bit, updated only on a granted cycle (0 = push, 1 = pull).
  - Reset value 1, so push wins the first conflict.
- Blocked requests (req high but not eligible) stay pending with no ack and no state change. Priority is not consumed.
- A request that loses arbitration is served the next cycle if it is still eligible. The maximum wait for an eligible request is 1 cycle.
- Back-to-back grants to the same side are allowed every cycle when the other side is idle.
- During rst high:
  - fifo_stb = 0, push_ack = 0, pull_ack = 0.
  - pull_valid resets to 0, pull_data to 0, last_grant to 1, level to 0.
- Reset mid-operation: a pull granted in the same cycle that rst is high is not issued, and no pull_valid follows.
- Outputs never issue a push when fifo_full = 1 or a pull when fifo_empty = 1.

Optional Feature:
- Macro: ARB_LEVEL_EN.
- Defined: an LW-bit counter tracks occupancy.
  - +1 on a push grant, -1 on a pull grant.
  - Saturates at 0 and SIZE-1; never wraps.
  - level drives the counter.
  - Formal/sim check: level == 0 iff fifo_empty, and level == SIZE-1 iff fifo_full.
- Not defined: no counter logic; level is tied to 0.

Test Plan:
- Reset, then idle: rst = 1 for 2 cycles, then no requests -> fifo_stb = 0, pull_valid = 0, level = 0.
- Fill: push_req held with data 0x01..0x0A, no pulls -> 9 push_acks (SIZE-1). The 10th push gets no ack while fifo_full = 1. level = 9 with ARB_LEVEL_EN.
- Drain: pull_req held after fill -> 9 pull_acks. pull_data = 0x01..0x09 in order, each one cycle after its ack. No ack once empty.
- Conflict: 4 entries queued, push_req and pull_req both held high -> grants alternate push, pull, push, pull. The first conflict after reset goes to push. level stays at 4/5.
- Empty + simultaneous requests: empty fifo, both requests high -> push granted (pull ineligible). Next cycle pull is granted and returns the just-pushed data.
- Reset mid-stream: assert rst in a cycle with pull_req high on a non-empty fifo -> no pull_ack, fifo_stb = 0, and pull_valid = 0 the following cycle.

Source files
------------

// File: rtl/fifo_port_arbiter_if.sv
// Client and FIFO-side signals of fifo_port_arbiter. The master modport is the arbiter;
// the slave modport is the client logic plus the fifo instance.
interface fifo_port_arbiter_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned LW = 4
);
  logic          push_req;
  logic [DW-1:0] push_data;
  logic          push_ack;
  logic          pull_req;
  logic          pull_ack;
  logic          pull_valid;
  logic [DW-1:0] pull_data;
  logic          fifo_op;
  logic          fifo_stb;
  logic [DW-1:0] fifo_data_write;
  logic [DW-1:0] fifo_data_read;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] level;

  modport master (
    input  push_req, push_data, pull_req, fifo_data_read, fifo_full, fifo_empty,
    output push_ack, pull_ack, pull_valid, pull_data, fifo_op, fifo_stb, fifo_data_write, level
  );

  modport slave (
    output push_req, push_data, pull_req, fifo_data_read, fifo_full, fifo_empty,
    input  push_ack, pull_ack, pull_valid, pull_data, fifo_op, fifo_stb, fifo_data_write, level
  );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Round-robin arbiter sharing a single-port FIFO command interface between a producer and
// a consumer. Define ARB_LEVEL_EN to add a saturating occupancy counter driven on level.
module fifo_port_arbiter #(
  parameter int unsigned DW   = 8,
  parameter int unsigned SIZE = 10,
  parameter int unsigned LW   = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_port_arbiter_if.master bus
);

  if ((2 ** LW) <= (SIZE - 1)) begin : g_lw_check
    $error("LW too narrow to count SIZE-1 entries");
  end

  logic          push_elig;
  logic          pull_elig;
  logic          push_gnt;
  logic          pull_gnt;
  logic          last_grant_q;
  logic          last_grant_d;
  logic          pull_valid_q;
  logic [DW-1:0] pull_data_q;

  assign push_elig = bus.push_req & ~bus.fifo_full;
  assign pull_elig = bus.pull_req & ~bus.fifo_empty;

  // last_grant_q: 0 = push served last, 1 = pull served last.
  always_comb begin
    push_gnt     = 1'b0;
    pull_gnt     = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      if (push_elig && pull_elig) begin
        push_gnt = last_grant_q;
        pull_gnt = ~last_grant_q;
      end else begin
        push_gnt = push_elig;
        pull_gnt = pull_elig;
      end
    end
    if (push_gnt || pull_gnt) begin
      last_grant_d = pull_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      pull_valid_q <= 1'b0;
      pull_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pull_valid_q <= pull_gnt;
      if (pull_gnt) begin
        pull_data_q <= bus.fifo_data_read;
      end
    end
  end

  assign bus.fifo_stb        = push_gnt | pull_gnt;
  assign bus.fifo_op         = pull_gnt;
  assign bus.fifo_data_write = bus.push_data;
  assign bus.push_ack        = push_gnt;
  assign bus.pull_ack        = pull_gnt;
  assign bus.pull_valid      = pull_valid_q;
  assign bus.pull_data       = pull_data_q;

`ifdef ARB_LEVEL_EN
  localparam logic [LW-1:0] LevelMax = LW'(SIZE - 1);

  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;

  always_comb begin
    level_d = level_q;
    if (push_gnt && (level_q != LevelMax)) begin
      level_d = level_q + 1'b1;
    end else if (pull_gnt && (level_q != '0)) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign bus.level = level_q;
`else
  assign bus.level = '0;
`endif

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Self-checking bench for fifo_port_arbiter: behavioural FIFO, grant model and a pull-data
// scoreboard checked every cycle, plus per-scenario tasks with inline checks.
module tb_fifo_port_arbiter;
  localparam int unsigned DW   = 8;
  localparam int unsigned SIZE = 10;
  localparam int unsigned LW   = 4;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic fifo_clear = 1'b1;
  logic mon_en     = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  fifo_port_arbiter_if #(.DW(DW), .LW(LW)) bus ();

  fifo_port_arbiter #(.DW(DW), .SIZE(SIZE), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port FIFO, one slot kept free.
  logic [DW-1:0] mem [SIZE];
  int unsigned   wp = 0;
  int unsigned   rp = 0;

  assign bus.fifo_empty     = (wp == rp);
  assign bus.fifo_full      = (((wp + 1) % SIZE) == rp);
  assign bus.fifo_data_read = mem[rp];

  always @(posedge clk) begin
    if (fifo_clear) begin
      wp <= 0;
      rp <= 0;
    end else if (bus.fifo_stb === 1'b1) begin
      if (bus.fifo_op === 1'b0) begin
        mem[wp] <= bus.fifo_data_write;
        wp      <= (wp + 1) % SIZE;
      end else begin
        rp <= (rp + 1) % SIZE;
      end
    end
  end

  // Grant model and scoreboard, evaluated mid-cycle.
  logic          m_last  = 1'b1;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_pdata = '0;
  int            m_level = 0;
  logic [DW-1:0] sb [$];
  logic          m_pe, m_le, m_gp, m_gl;
  logic [LW-1:0] m_exp_lvl;

  always @(negedge clk) begin
    if (mon_en) begin
      m_gp = 1'b0;
      m_gl = 1'b0;
      if (!rst) begin
        m_pe = bus.push_req && !bus.fifo_full;
        m_le = bus.pull_req && !bus.fifo_empty;
        m_gp = m_pe && (!m_le || m_last);
        m_gl = m_le && (!m_pe || !m_last);
      end
      vectors++;
      if (bus.push_ack !== m_gp || bus.pull_ack !== m_gl) begin
        miscompares++;
        $display("FAIL grant t=%0t: push_ack/pull_ack=%b%b, required %b%b", $time,
                 bus.push_ack, bus.pull_ack, m_gp, m_gl);
      end
      vectors++;
      if (bus.fifo_stb !== (m_gp | m_gl)) begin
        miscompares++;
        $display("FAIL fifo_stb t=%0t: got %b, required %b", $time, bus.fifo_stb, m_gp | m_gl);
      end
      if (m_gp || m_gl) begin
        vectors++;
        if (bus.fifo_op !== m_gl) begin
          miscompares++;
          $display("FAIL fifo_op t=%0t: got %b, required %b", $time, bus.fifo_op, m_gl);
        end
      end
      if (m_gp) begin
        vectors++;
        if (bus.fifo_data_write !== bus.push_data) begin
          miscompares++;
          $display("FAIL data_write t=%0t: got %h, required %h", $time,
                   bus.fifo_data_write, bus.push_data);
        end
      end
      vectors++;
      if (bus.pull_valid !== m_valid) begin
        miscompares++;
        $display("FAIL pull_valid t=%0t: got %b, required %b", $time, bus.pull_valid, m_valid);
      end
      vectors++;
      if (bus.pull_data !== m_pdata) begin
        miscompares++;
        $display("FAIL pull_data t=%0t: got %h, required %h", $time, bus.pull_data, m_pdata);
      end
`ifdef ARB_LEVEL_EN
      m_exp_lvl = LW'(m_level);
`else
      m_exp_lvl = '0;
`endif
      vectors++;
      if (bus.level !== m_exp_lvl) begin
        miscompares++;
        $display("FAIL level t=%0t: got %0d, required %0d", $time, bus.level, m_exp_lvl);
      end
      // Advance the model to the state the DUT takes at the next edge.
      if (rst) begin
        m_last  = 1'b1;
        m_valid = 1'b0;
        m_pdata = '0;
        m_level = 0;
        sb.delete();
      end else begin
        if (m_gp) sb.push_back(bus.push_data);
        m_valid = m_gl;
        if (m_gl) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t: pull granted with 0 entries, required >0", $time);
          end else begin
            m_pdata = sb.pop_front();
          end
        end
        if (m_gp || m_gl) m_last = m_gl;
        if (m_gp && m_level != int'(SIZE - 1)) m_level++;
        else if (m_gl && m_level != 0) m_level--;
      end
    end
  end

  // Stimulus helpers: drive only, no checking.
  task automatic drive_push(input int n, input logic [DW-1:0] first, output int got);
    logic took;
    got           = 0;
    bus.push_data = first;
    bus.push_req  = 1'b1;
    for (int i = 0; i < n + 8 && got < n; i++) begin
      @(negedge clk);
      took = bus.push_ack;
      @(posedge clk); #1;
      if (took) begin
        got++;
        bus.push_data = bus.push_data + 1'b1;
      end
    end
    bus.push_req = 1'b0;
  endtask

  task automatic drive_pull(input int n, output int got);
    logic took;
    got          = 0;
    bus.pull_req = 1'b1;
    for (int i = 0; i < n + 8 && got < n; i++) begin
      @(negedge clk);
      took = bus.pull_ack;
      @(posedge clk); #1;
      if (took) got++;
    end
    bus.pull_req = 1'b0;
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    fifo_clear    = 1'b1;
    bus.push_req  = 1'b1;
    bus.pull_req  = 1'b1;
    bus.push_data = 8'hEE;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.fifo_stb !== 1'b0 || bus.push_ack !== 1'b0 || bus.pull_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_gating: stb/push_ack/pull_ack=%b%b%b, required 000",
               bus.fifo_stb, bus.push_ack, bus.pull_ack);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    fifo_clear   = 1'b0;
    bus.push_req = 1'b0;
    bus.pull_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.fifo_stb !== 1'b0 || bus.pull_valid !== 1'b0 || bus.level !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: stb=%b pull_valid=%b level=%0d, required 0 0 0",
               bus.fifo_stb, bus.pull_valid, bus.level);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    int   acks = 0;
    logic took;
    bus.push_data = 8'h01;
    bus.push_req  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      took = bus.push_ack;
      if (took) acks++;
      @(posedge clk); #1;
      if (took) bus.push_data = bus.push_data + 1'b1;
    end
    @(negedge clk);
    vectors++;
    if (acks != int'(SIZE - 1)) begin
      miscompares++;
      $display("FAIL fill_acks: got %0d, required %0d", acks, SIZE - 1);
    end
    vectors++;
    if (bus.push_ack !== 1'b0 || bus.fifo_full !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_blocked: push_ack=%b full=%b, required 0 1", bus.push_ack,
               bus.fifo_full);
    end
`ifdef ARB_LEVEL_EN
    vectors++;
    if (bus.level !== LW'(SIZE - 1)) begin
      miscompares++;
      $display("FAIL fill_level: got %0d, required %0d", bus.level, SIZE - 1);
    end
`endif
    @(posedge clk); #1;
    bus.push_req = 1'b0;
  endtask

  task automatic test_drain;
    int            acks = 0;
    logic [DW-1:0] d    = 8'h01;
    bus.pull_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.pull_ack) acks++;
      if (bus.pull_valid) begin
        vectors++;
        if (bus.pull_data !== d) begin
          miscompares++;
          $display("FAIL drain_data: got %h, required %h", bus.pull_data, d);
        end
        d = d + 1'b1;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++;
    if (acks != int'(SIZE - 1) || d != 8'h0A) begin
      miscompares++;
      $display("FAIL drain_count: acks=%0d next=%h, required 9 0a", acks, d);
    end
    vectors++;
    if (bus.pull_ack !== 1'b0 || bus.fifo_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_empty: pull_ack=%b empty=%b, required 0 1", bus.pull_ack,
               bus.fifo_empty);
    end
    @(posedge clk); #1;
    bus.pull_req = 1'b0;
  endtask

  task automatic test_conflict;
    int   got;
    logic took;
    logic exp_p;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_push(5, 8'h21, got);
    vectors++;
    if (got != 5) begin
      miscompares++;
      $display("FAIL conflict_setup_push: got %0d, required 5", got);
    end
    drive_pull(1, got);
    bus.push_data = 8'h26;
    bus.push_req  = 1'b1;
    bus.pull_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_p = (i % 2 == 0);
      vectors++;
      if (bus.push_ack !== exp_p || bus.pull_ack !== !exp_p) begin
        miscompares++;
        $display("FAIL conflict_rr[%0d]: push_ack/pull_ack=%b%b, required %b%b", i,
                 bus.push_ack, bus.pull_ack, exp_p, !exp_p);
      end
      took = bus.push_ack;
      @(posedge clk); #1;
      if (took) bus.push_data = bus.push_data + 1'b1;
    end
    bus.push_req = 1'b0;
    bus.pull_req = 1'b0;
    drive_pull(4, got);
    @(negedge clk);
    vectors++;
    if (got != 4 || bus.fifo_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_drain: pulls=%0d empty=%b, required 4 1", got, bus.fifo_empty);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_empty_both;
    bus.push_data = 8'h5A;
    bus.push_req  = 1'b1;
    bus.pull_req  = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.push_ack !== 1'b1 || bus.pull_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_both_push: push_ack/pull_ack=%b%b, required 10", bus.push_ack,
               bus.pull_ack);
    end
    @(posedge clk); #1;
    bus.push_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.pull_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_both_pull: pull_ack=%b, required 1", bus.pull_ack);
    end
    @(posedge clk); #1;
    bus.pull_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.pull_valid !== 1'b1 || bus.pull_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL empty_both_data: valid=%b data=%h, required 1 5a", bus.pull_valid,
               bus.pull_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream;
    int got;
    drive_push(3, 8'h31, got);
    rst          = 1'b1;
    bus.pull_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.pull_ack !== 1'b0 || bus.fifo_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_gate: pull_ack=%b stb=%b, required 0 0", bus.pull_ack,
               bus.fifo_stb);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.pull_req = 1'b0;
    fifo_clear   = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.pull_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_valid: got %b, required 0", bus.pull_valid);
    end
    @(posedge clk); #1;
    fifo_clear = 1'b0;
  endtask

  task automatic test_back_to_back;
    bus.push_data = 8'h41;
    bus.push_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.push_ack !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_push[%0d]: got %b, required 1", i, bus.push_ack);
      end
      @(posedge clk); #1;
      bus.push_data = bus.push_data + 1'b1;
    end
    bus.push_req = 1'b0;
    bus.pull_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.pull_ack !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_pull[%0d]: got %b, required 1", i, bus.pull_ack);
      end
      @(posedge clk); #1;
    end
    bus.pull_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.pull_valid !== 1'b1 || bus.pull_data !== 8'h43) begin
      miscompares++;
      $display("FAIL b2b_last: valid=%b data=%h, required 1 43", bus.pull_valid,
               bus.pull_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.push_req  = 1'b0;
    bus.pull_req  = 1'b0;
    bus.push_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_conflict();
    test_empty_both();
    test_reset_midstream();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
    $fatal(1);
  end

endmodule
